adc_spi_sequencer: RTL and testbench
====================================

Name: adc_spi_sequencer

Overview:
- SPI master that sequences the 12-bit serial ADC (16-bit frame: 4 protocol bits, then 12 data bits, MSB first).
- Generates CS_n and SCLK, shifts in SDATA, and presents a parallel 16-bit word plus a one-cycle valid strobe.
- Sits between the ADC pins and the offset-removal stage, which consumes the 16-bit word.
- One conversion per accepted Inicio request.

Parameters:
- CLK_DIV, 4: system-clock cycles per SCLK half-period; minimum 2.
- QUIET_CYCLES, 2: minimum CS_n-high cycles after a frame before the block returns to IDLE; minimum 1.
- FRAME_BITS, 16: bits per conversion frame; fixed at 16, exposed for the package constant.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  reset, synchronous, active-high.
- Inicio  in  1  conversion request; sampled only in IDLE.
- SDATA  in  1  ADC serial data.
- CS_n  out  1  ADC chip select, active-low.
- SCLK  out  1  ADC serial clock; idles high.
- Dato_OUT  out  16  last completed frame.
- Dato_Valido  out  1  one-cycle pulse; Dato_OUT is new in this cycle.
- Ocupado  out  1  high from the cycle after Inicio is accepted until the block is back in IDLE.

Behaviour:
- Reset values (registered outputs, all take effect the cycle after Reset is seen high):
  - CS_n=1, SCLK=1, Dato_OUT=16'h0000, Dato_Valido=0, Ocupado=0.
  - State goes to IDLE; divider, bit counter and shift register are cleared.
- FSM states: IDLE, SETUP, SHIFT, HOLD, QUIET.
- IDLE:
  - CS_n=1, SCLK=1.
  - Inicio=1 moves to SETUP; CS_n=0 and Ocupado=1 in the next cycle.
- SETUP:
  - CS_n=0, SCLK=1 for CLK_DIV cycles, then SHIFT.
- SHIFT, 16 bit periods of 2*CLK_DIV cycles each:
  - SCLK is low for the first CLK_DIV cycles of a period and high for the second CLK_DIV cycles.
  - SDATA is sampled into the shift register (shift left, LSB in) on the cycle SCLK goes 0->1.
  - After the 16th rising edge plus CLK_DIV high cycles, go to HOLD.
- HOLD:
  - CS_n=0, SCLK=1 for CLK_DIV cycles, then QUIET.
- QUIET:
  - CS_n=1, SCLK=1 for QUIET_CYCLES cycles, then IDLE; Ocupado drops on entry to IDLE.
  - In the first QUIET cycle: Dato_OUT <= shift register and Dato_Valido=1 for that one cycle.
- Timing:
  - CS_n low time is exactly 34*CLK_DIV cycles (136 for the defaults).
  - Minimum CS_n high time between frames is QUIET_CYCLES+1.
- Inicio outside IDLE is ignored: no queueing, no error.
- Reset mid-frame aborts the frame: no Dato_Valido, Dato_OUT keeps its reset value.
- Dato_OUT holds its value between frames.
- Counters:
  - Divider width is $clog2(CLK_DIV).
  - Bit counter is 5 bits and counts 0..15; it does not wrap past 15 within a frame.

Optional Feature:
- Macro: ADC_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output port Error_Protocolo (1 bit, reset value 0).
  - At frame end, if captured bits [15:12] != 4'b0000: Error_Protocolo pulses for one cycle in the first QUIET cycle, Dato_Valido stays 0, and Dato_OUT is not updated.
- Undefined:
  - The port is absent and every completed frame produces Dato_Valido.

Decomposition:
- Shared package adc_pkg:
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, QUIET).
  - FRAME_BITS=16, PROTO_BITS=4, DATA_BITS=12.
  - PROTO_OK=4'b0000.
- Sub-module adc_sclk_tick:
  - Divider that, when enabled, emits single-cycle fall_tick and rise_tick strobes and phase-count terminal counts.
  - The FSM instantiates it once.

Test Plan:
- Basic frame:
  - Stimulus: Reset, then Inicio pulse; ADC model drives 16'h0ABC.
  - Response: CS_n low for 136 cycles, exactly 16 SCLK rising edges, Dato_OUT=16'h0ABC, one-cycle Dato_Valido coincident with CS_n rising.
- Inicio while busy:
  - Stimulus: Inicio pulsed every 10 cycles during a frame.
  - Response: single frame only; the next Inicio is accepted only after Ocupado=0.
- Reset mid-frame:
  - Stimulus: Reset asserted at the 8th SCLK rising edge.
  - Response: CS_n=1 and SCLK=1 the next cycle, no Dato_Valido, Dato_OUT=16'h0000.
- Continuous Inicio:
  - Stimulus: Inicio held high with QUIET_CYCLES=2; model words 16'h0FFF then 16'h0001.
  - Response: frames separated by exactly 3 CS_n-high cycles; Dato_OUT sequence 16'h0FFF then 16'h0001.
- Protocol check:
  - Stimulus: model drives 16'h8123.
  - Response with ADC_PROTOCOL_CHECK_EN: Error_Protocolo pulses, no Dato_Valido, Dato_OUT unchanged.
  - Response without the macro: Dato_Valido pulses and Dato_OUT=16'h8123.
- Minimum divider:
  - Stimulus: CLK_DIV=2.
  - Response: CS_n low for 68 cycles, SCLK period 4 cycles, correct capture of 16'h0555.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: shared frame constants and FSM state encoding for the ADC SPI sequencer.
// Contents: frame geometry (FRAME_BITS, PROTO_BITS, DATA_BITS), the expected
// protocol nibble PROTO_OK, and the state_t encoding with its ST_* constants.
package adc_pkg;
    localparam int FRAME_BITS = 16;
    localparam int PROTO_BITS = 4;
    localparam int DATA_BITS  = 12;
    localparam logic [PROTO_BITS-1:0] PROTO_OK = 4'b0000;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_QUIET = 3'd4;
endpackage

// File: rtl/adc_sclk_tick.sv
// adc_sclk_tick: SCLK half-period divider producing terminal-count and edge strobes.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         counting enable; while low the counter and phase are held cleared
//   phase      current half-period: 0 = first half after enable, toggles every CLK_DIV cycles
//   tc         last cycle of the current half-period
//   fall_tick  tc while phase=0 (the SCLK-high half ends, SCLK falls next)
//   rise_tick  tc while phase=1 (the SCLK-low half ends, SCLK rises next)
module adc_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase,
    output logic tc,
    output logic fall_tick,
    output logic rise_tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    assign tc        = en && cnt == LAST;
    assign rise_tick = tc && phase;
    assign fall_tick = tc && !phase;
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt   <= tc ? '0 : cnt + 1'b1;
            phase <= phase ^ tc;
        end
    end
endmodule

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: SPI master that runs one 16-bit conversion frame of the serial ADC per request.
// Ports:
//   Clk, Reset    system clock, synchronous active-high reset
//   Inicio        conversion request, sampled only while idle
//   SDATA         ADC serial data, captured MSB first on each SCLK rising edge
//   CS_n, SCLK    ADC chip select (active low) and serial clock (idles high)
//   Dato_OUT      last accepted frame, held between frames
//   Dato_Valido   one-cycle strobe, Dato_OUT is new in this cycle
//   Ocupado       busy from the cycle after a request is accepted until back in idle
//   Error_Protocolo  (only with ADC_PROTOCOL_CHECK_EN) one-cycle strobe when the
//                 leading protocol nibble is not zero; such frames are dropped
// Optional macro: ADC_PROTOCOL_CHECK_EN enables the protocol-nibble check.
// All outputs are registered from the next-state value so they change in the
// same cycle the state does.
module adc_spi_sequencer import adc_pkg::*; #(
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 2,
    parameter int FRAME_BITS   = adc_pkg::FRAME_BITS
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Inicio,
    input  logic                  SDATA,
    output logic                  CS_n,
    output logic                  SCLK,
    output logic [FRAME_BITS-1:0] Dato_OUT,
    output logic                  Dato_Valido,
    output logic                  Ocupado
`ifdef ADC_PROTOCOL_CHECK_EN
    ,
    output logic                  Error_Protocolo
`endif
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
    state_t state, ns;
    logic [4:0] bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [QW-1:0] q_cnt;
    logic div_en, phase, tc, fall_tick, rise_tick, frame_done, accept;
    assign div_en     = state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD;
    assign frame_done = state == ST_HOLD && tc;
    adc_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(Clk), .rst(Reset), .en(div_en),
        .phase(phase), .tc(tc), .fall_tick(fall_tick), .rise_tick(rise_tick)
    );
    // Each SHIFT bit period is a low half (phase=1) then a high half (phase=0);
    // the period ends on fall_tick, and the last one hands over to HOLD.
    always_comb begin
        ns = state;
        case (state)
            ST_IDLE:  if (Inicio) ns = ST_SETUP;
            ST_SETUP: if (tc) ns = ST_SHIFT;
            ST_SHIFT: if (fall_tick && bit_cnt == LAST_BIT) ns = ST_HOLD;
            ST_HOLD:  if (tc) ns = ST_QUIET;
            ST_QUIET: if (q_cnt == Q_LAST) ns = ST_IDLE;
            default:  ns = ST_IDLE;
        endcase
    end
`ifdef ADC_PROTOCOL_CHECK_EN
    logic proto_ok;
    assign proto_ok = shreg[FRAME_BITS-1 -: PROTO_BITS] == PROTO_OK;
    assign accept   = frame_done && proto_ok;
    always_ff @(posedge Clk) Error_Protocolo <= !Reset && frame_done && !proto_ok;
`else
    assign accept = frame_done;
`endif
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            q_cnt       <= '0;
            CS_n        <= 1'b1;
            SCLK        <= 1'b1;
            Dato_OUT    <= '0;
            Dato_Valido <= 1'b0;
            Ocupado     <= 1'b0;
        end else begin
            state       <= ns;
            bit_cnt     <= state != ST_SHIFT ? '0 : (fall_tick && bit_cnt != LAST_BIT) ? bit_cnt + 5'd1 : bit_cnt;
            shreg       <= (state == ST_SHIFT && rise_tick) ? {shreg[FRAME_BITS-2:0], SDATA} : shreg;
            q_cnt       <= state == ST_QUIET ? q_cnt + 1'b1 : '0;
            CS_n        <= ns == ST_IDLE || ns == ST_QUIET;
            // phase ^ tc is the divider phase of the next cycle; phase 1 is the low half
            SCLK        <= !(ns == ST_SHIFT && (phase ^ tc));
            Ocupado     <= ns != ST_IDLE;
            Dato_Valido <= accept;
            Dato_OUT    <= accept ? shreg : Dato_OUT;
        end
    end
endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer: scoreboard bench for adc_spi_sequencer (default divider and CLK_DIV=2 instances).
module tb_adc_spi_sequencer;
    logic Clk = 1'b0, Reset = 1'b1, Inicio = 1'b0, SDATA = 1'b0, Inicio2 = 1'b0, SDATA2 = 1'b0;
    logic CS_n, SCLK, Dato_Valido, Ocupado, CS_n2, SCLK2, Dato_Valido2, Ocupado2;
    logic [15:0] Dato_OUT, Dato_OUT2;
`ifdef ADC_PROTOCOL_CHECK_EN
    logic Error_Protocolo, Error_Protocolo2;
`endif
    int tests = 0, fails = 0;
    always #5 Clk = ~Clk;

    adc_spi_sequencer u_dut (
        .Clk(Clk), .Reset(Reset), .Inicio(Inicio), .SDATA(SDATA), .CS_n(CS_n), .SCLK(SCLK),
        .Dato_OUT(Dato_OUT), .Dato_Valido(Dato_Valido), .Ocupado(Ocupado)
`ifdef ADC_PROTOCOL_CHECK_EN
        , .Error_Protocolo(Error_Protocolo)
`endif
    );
    adc_spi_sequencer #(.CLK_DIV(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .Inicio(Inicio2), .SDATA(SDATA2), .CS_n(CS_n2), .SCLK(SCLK2),
        .Dato_OUT(Dato_OUT2), .Dato_Valido(Dato_Valido2), .Ocupado(Ocupado2)
`ifdef ADC_PROTOCOL_CHECK_EN
        , .Error_Protocolo(Error_Protocolo2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC models: a new word per CS_n fall, one bit (MSB first) per SCLK fall.
    logic [15:0] word_q[$], word2_q[$], exp_q[$], exp2_q[$];
    logic [15:0] cur = 16'h0, cur2 = 16'h0;
    int idx = -1, idx2 = -1;
    always @(negedge CS_n) begin cur = word_q.size() > 0 ? word_q.pop_front() : 16'h0; idx = 15; end
    always @(negedge SCLK) if (!CS_n && idx >= 0) begin SDATA = cur[idx]; idx--; end
    always @(negedge CS_n2) begin cur2 = word2_q.size() > 0 ? word2_q.pop_front() : 16'h0; idx2 = 15; end
    always @(negedge SCLK2) if (!CS_n2 && idx2 >= 0) begin SDATA2 = cur2[idx2]; idx2--; end

    // Monitor for the default instance.
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    int low_run = 0, high_run = 0, last_low = 0, last_high = 0, rises = 0;
    int starts = 0, frames = 0, valids = 0, errs = 0;
    always @(negedge Clk) begin
        if (prev_cs && !CS_n) begin last_high = high_run; high_run = 0; low_run = 0; rises = 0; starts++; end
        if (!CS_n) low_run++; else high_run++;
        if (!prev_cs && CS_n) begin last_low = low_run; frames++; end
        if (!prev_sclk && SCLK && !CS_n) rises++;
        if (Dato_Valido) begin
            valids++;
            check("valid_at_cs_rise", {30'd0, prev_cs, CS_n}, 32'd1);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid: got Dato_OUT=%0h with nothing expected", Dato_OUT);
            end else check("scoreboard_data", Dato_OUT, exp_q.pop_front());
        end
`ifdef ADC_PROTOCOL_CHECK_EN
        if (Error_Protocolo) errs++;
`endif
        prev_cs = CS_n;
        prev_sclk = SCLK;
    end

    // Monitor for the CLK_DIV=2 instance.
    logic prev_cs2 = 1'b1, prev_sclk2 = 1'b1;
    int low_run2 = 0, last_low2 = 0, rises2 = 0, valids2 = 0, cyc = 0, last_rise_cyc = 0, period2 = 0;
    always @(negedge Clk) begin
        cyc++;
        if (prev_cs2 && !CS_n2) begin low_run2 = 0; rises2 = 0; end
        if (!CS_n2) low_run2++;
        if (!prev_cs2 && CS_n2) last_low2 = low_run2;
        if (!prev_sclk2 && SCLK2 && !CS_n2) begin
            if (rises2 > 0) period2 = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
            rises2++;
        end
        if (Dato_Valido2) begin
            valids2++;
            if (exp2_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid2: got Dato_OUT2=%0h with nothing expected", Dato_OUT2);
            end else check("scoreboard_data2", Dato_OUT2, exp2_q.pop_front());
        end
        prev_cs2 = CS_n2;
        prev_sclk2 = SCLK2;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input bit expect_valid);
        word_q.push_back(w);
        if (expect_valid) exp_q.push_back(w);
    endtask

    task automatic pulse();
        Inicio = 1'b1;
        tick();
        Inicio = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        tick(2);
        while (Ocupado && n < 5000) begin tick(); n++; end
        if (Ocupado) begin
            tests++; fails++;
            $display("FAIL %s: timeout, Ocupado still 1", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int f0, s0, v0, e0, r, n;
    logic ps;
    initial begin
        Reset = 1'b1;
        tick(3);
        check("rst_cs_n", CS_n, 1);
        check("rst_sclk", SCLK, 1);
        check("rst_dato", Dato_OUT, 16'h0000);
        check("rst_valid", Dato_Valido, 0);
        check("rst_ocupado", Ocupado, 0);
        Reset = 1'b0;
        tick(2);

        // Basic frame
        push(16'h0ABC, 1);
        v0 = valids;
        pulse();
        check("accept_cs_n", CS_n, 0);
        check("accept_ocupado", Ocupado, 1);
        wait_idle("basic");
        check("basic_cs_low", last_low, 136);
        check("basic_rises", rises, 16);
        check("basic_valids", valids - v0, 1);
        check("basic_dato", Dato_OUT, 16'h0ABC);

        // Inicio pulsed every 10 cycles while busy
        push(16'h0123, 1);
        f0 = frames; s0 = starts;
        pulse();
        for (n = 0; Ocupado && n < 50; n++) begin
            tick(9);
            if (Ocupado) pulse();
        end
        tick(20);
        check("busy_starts", starts - s0, 1);
        check("busy_frames", frames - f0, 1);
        check("busy_dato", Dato_OUT, 16'h0123);
        check("busy_cs_idle", CS_n, 1);

        // Reset at the 8th SCLK rising edge
        push(16'h0FFF, 0);
        v0 = valids;
        pulse();
        r = 0; ps = SCLK;
        for (n = 0; r < 8 && n < 2000; n++) begin
            tick();
            if (!ps && SCLK) r++;
            ps = SCLK;
        end
        check("rst_mid_rises", r, 8);
        Reset = 1'b1;
        tick();
        check("rst_mid_cs_n", CS_n, 1);
        check("rst_mid_sclk", SCLK, 1);
        Reset = 1'b0;
        tick(200);
        check("rst_mid_valids", valids - v0, 0);
        check("rst_mid_dato", Dato_OUT, 16'h0000);
        check("rst_mid_ocupado", Ocupado, 0);

        // Continuous Inicio: two back-to-back frames
        push(16'h0FFF, 1);
        push(16'h0001, 1);
        f0 = frames; s0 = starts;
        Inicio = 1'b1;
        for (n = 0; starts - s0 < 2 && n < 2000; n++) tick();
        Inicio = 1'b0;
        wait_idle("continuous");
        check("cont_starts", starts - s0, 2);
        check("cont_frames", frames - f0, 2);
        check("cont_gap", last_high, 3);
        check("cont_dato", Dato_OUT, 16'h0001);

        // Non-zero protocol nibble
        v0 = valids; e0 = errs;
`ifdef ADC_PROTOCOL_CHECK_EN
        push(16'h8123, 0);
        pulse();
        wait_idle("proto");
        check("proto_err", errs - e0, 1);
        check("proto_valids", valids - v0, 0);
        check("proto_dato", Dato_OUT, 16'h0001);
`else
        push(16'h8123, 1);
        pulse();
        wait_idle("proto");
        check("proto_valids", valids - v0, 1);
        check("proto_dato", Dato_OUT, 16'h8123);
`endif

        // Minimum divider instance
        word2_q.push_back(16'h0555);
        exp2_q.push_back(16'h0555);
        Inicio2 = 1'b1;
        tick();
        Inicio2 = 1'b0;
        tick(2);
        for (n = 0; Ocupado2 && n < 2000; n++) tick();
        check("div2_idle", Ocupado2, 0);
        check("div2_cs_low", last_low2, 68);
        check("div2_period", period2, 4);
        check("div2_rises", rises2, 16);
        check("div2_valids", valids2, 1);
        check("div2_dato", Dato_OUT2, 16'h0555);

        tick(5);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp2_q_drained", exp2_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
